// File: rtl/instr_encoder_loader.sv
// MIPS instruction encoder feeding an instruction-memory write stream.
// Optional ENCODER_NOP_PAD_EN: pad the session with NOPs up to DEPTH on finish.
module instr_encoder_loader #(
  parameter int ADDR_W    = 32,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [15:0]       word_count,
  output logic              done,
  output logic              err,
  output logic [5:0]        err_mnem
);

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [15:0]       DEPTH_C = 16'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
`ifdef ENCODER_NOP_PAD_EN
    S_PAD,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] nxt_q, nxt_d;
  logic [15:0]       wc_q, wc_d;
  logic              err_q, err_d;
  logic [5:0]        emn_q, emn_d;
  logic              fin_q, fin_d;

  logic [31:0] enc;
  logic [31:0] r_base, s_base, i_base, z_base;
  logic        legal, accept, room;

  assign r_base = {6'd0, in_rs, in_rt, in_rd, 11'd0};
  assign s_base = {11'd0, in_rt, in_rd, in_shamt, 6'd0};
  assign i_base = {6'd0, in_rs, in_rt, in_imm};
  assign z_base = {6'd0, in_rs, 5'd0, in_imm};

  always_comb begin
    enc = '0;
    unique case (in_mnem)
      6'd1:  enc = r_base | 32'h20;
      6'd2:  enc = r_base | 32'h21;
      6'd3:  enc = r_base | 32'h24;
      6'd4:  enc = r_base | 32'h27;
      6'd5:  enc = r_base | 32'h25;
      6'd6:  enc = r_base | 32'h2A;
      6'd7:  enc = r_base | 32'h2B;
      6'd8:  enc = r_base | 32'h22;
      6'd9:  enc = r_base | 32'h23;
      6'd10: enc = r_base | 32'h26;
      6'd11: enc = r_base | 32'h04;
      6'd12: enc = r_base | 32'h07;
      6'd13: enc = r_base | 32'h06;
      6'd14: enc = s_base;
      6'd15: enc = s_base | 32'h03;
      6'd16: enc = s_base | 32'h02;
      6'd17: enc = {6'd0, in_rs, 21'h8};
      6'd18: enc = {6'h04, i_base[25:0]};
      6'd19: enc = {6'h05, i_base[25:0]};
      6'd20: enc = {6'h01, z_base[25:0]} | 32'h0001_0000;
      6'd21: enc = {6'h07, z_base[25:0]};
      6'd22: enc = {6'h06, z_base[25:0]};
      6'd23: enc = {6'h01, z_base[25:0]};
      6'd24: enc = {6'h02, in_target};
      6'd25: enc = {6'h08, i_base[25:0]};
      6'd26: enc = {6'h09, i_base[25:0]};
      6'd27: enc = {6'h0C, i_base[25:0]};
      6'd28: enc = {6'h0E, i_base[25:0]};
      6'd29: enc = {6'h0D, i_base[25:0]};
      6'd30: enc = {6'h0A, i_base[25:0]};
      6'd31: enc = {6'h0B, i_base[25:0]};
      6'd32: enc = {6'h23, i_base[25:0]};
      6'd33: enc = {6'h2B, i_base[25:0]};
      default: enc = '0;
    endcase
  end

  assign legal    = (in_mnem <= 6'd33);
  assign room     = !out_valid_q || out_ready;
  assign in_ready = (state_q == S_LOAD) && !fin_q &&
                    (wc_q < DEPTH_C) && room;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    nxt_d       = nxt_q;
    wc_d        = wc_q;
    err_d       = err_q;
    emn_d       = emn_q;
    fin_d       = fin_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          wc_d    = '0;
          err_d   = 1'b0;
          emn_d   = '0;
          nxt_d   = BASE_A;
          fin_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (finish) fin_d = 1'b1;
        if (accept) begin
          if (legal) begin
            out_valid_d = 1'b1;
            wdata_d     = enc;
            addr_d      = nxt_q;
            nxt_d       = nxt_q + ADDR_W'(4);
            wc_d        = wc_q + 16'd1;
          end else if (!err_q) begin
            err_d = 1'b1;
            emn_d = in_mnem;
          end
        end else if (!out_valid_q &&
                     (wc_q == DEPTH_C || fin_q)) begin
          fin_d = 1'b0;
`ifdef ENCODER_NOP_PAD_EN
          state_d = (wc_q < DEPTH_C) ? S_PAD : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef ENCODER_NOP_PAD_EN
      S_PAD: begin
        if (wc_q < DEPTH_C) begin
          if (room) begin
            out_valid_d = 1'b1;
            wdata_d     = '0;
            addr_d      = nxt_q;
            nxt_d       = nxt_q + ADDR_W'(4);
            wc_d        = wc_q + 16'd1;
          end
        end else if (!out_valid_q) begin
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= BASE_A;
      nxt_q       <= BASE_A;
      wc_q        <= '0;
      err_q       <= 1'b0;
      emn_q       <= '0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      nxt_q       <= nxt_d;
      wc_q        <= wc_d;
      err_q       <= err_d;
      emn_q       <= emn_d;
      fin_q       <= fin_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = wc_q;
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign err_mnem   = emn_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4).
// Pad-session expectations follow ENCODER_NOP_PAD_EN.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset, start, finish, in_valid, out_ready;
  logic        in_ready, out_valid, done, err;
  logic [5:0]  in_mnem, err_mnem;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm, word_count;
  logic [25:0] in_target;
  logic [31:0] imem_addr, imem_wdata;

  int errs = 0;
  int checks = 0;

  instr_encoder_loader #(.ADDR_W(32), .BASE_ADDR(0), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .done(done), .err(err),
    .err_mnem(err_mnem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; finish = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_imm = '0; in_target = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [5:0] m, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt);
    bit ok;
    ok = 1'b0;
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && !done; i++) step();
    chk("done", {31'd0, done}, 32'd1);
  endtask

  int pads;
  bit pad_zero;
  bit pad_addr;

  initial begin
    do_reset();
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_count", {16'd0, word_count}, 0);

    // ADD r3 = r1 + r2
    do_start();
    chk("load_in_ready", {31'd0, in_ready}, 1);
    send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    chk("add_valid", {31'd0, out_valid}, 1);
    chk("add_addr", imem_addr, 32'h0);
    chk("add_data", imem_wdata, 32'h0022_1820);
    chk("add_count", {16'd0, word_count}, 1);

    // back-to-back LW / BGEZ
    do_reset();
    do_start();
    send(6'd32, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'd0);
    chk("lw_data", imem_wdata, 32'h8FA8_0004);
    chk("lw_addr", imem_addr, 32'h0);
    send(6'd20, 5'd5, 5'd0, 5'd0, 5'd0, 16'hFFFE, 26'd0);
    chk("bgez_valid", {31'd0, out_valid}, 1);
    chk("bgez_data", imem_wdata, 32'h04A1_FFFE);
    chk("bgez_addr", imem_addr, 32'h4);
    step();
    chk("b2b_drained", {31'd0, out_valid}, 0);

    // SLL with backpressure; rs is ignored
    do_reset();
    do_start();
    out_ready = 1'b0;
    send(6'd14, 5'd7, 5'd4, 5'd4, 5'd2, 16'd0, 26'd0);
    for (int i = 0; i < 3; i++) begin
      chk("sll_hold_data", imem_wdata, 32'h0004_2080);
      chk("sll_hold_valid", {31'd0, out_valid}, 1);
      chk("sll_hold_rdy", {31'd0, in_ready}, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("sll_rdy_back", {31'd0, in_ready}, 1);
    step();
    chk("sll_drained", {31'd0, out_valid}, 0);

    // illegal mnemonics, then J
    do_reset();
    do_start();
    send(6'd40, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0);
    chk("ill_no_word", {31'd0, out_valid}, 0);
    send(6'd63, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    send(6'd24, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h010_0000);
    chk("err", {31'd0, err}, 1);
    chk("err_mnem", {26'd0, err_mnem}, 40);
    chk("j_data", imem_wdata, 32'h0810_0000);
    chk("j_addr", imem_addr, 32'h0);
    chk("j_count", {16'd0, word_count}, 1);

    // fill to DEPTH, then restart
    do_reset();
    do_start();
    send(6'd50, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    for (int i = 0; i < 4; i++)
      send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    chk("full_count", {16'd0, word_count}, 4);
    chk("full_addr", imem_addr, 32'hC);
    chk("full_in_ready", {31'd0, in_ready}, 0);
    in_valid = 1'b1;
    step();
    chk("full_stays_low", {31'd0, in_ready}, 0);
    in_valid = 1'b0;
    wait_done();
    chk("full_err", {31'd0, err}, 1);
    do_start();
    chk("restart_err", {31'd0, err}, 0);
    chk("restart_count", {16'd0, word_count}, 0);
    chk("restart_done", {31'd0, done}, 0);
    send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    chk("restart_addr", imem_addr, 32'h0);

    // finish after one word
    do_reset();
    do_start();
    send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    chk("fin_first", imem_addr, 32'h0);
    finish = 1'b1;
    step();
    finish = 1'b0;
    pads = 0;
    pad_zero = 1'b1;
    pad_addr = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      if (out_valid) begin
        pads++;
        if (imem_wdata != 32'd0) pad_zero = 1'b0;
        if (imem_addr != 32'(4 * pads)) pad_addr = 1'b0;
      end
      step();
    end
    chk("fin_done", {31'd0, done}, 1);
`ifdef ENCODER_NOP_PAD_EN
    chk("pad_words", pads, 3);
    chk("pad_count", {16'd0, word_count}, 4);
`else
    chk("pad_words", pads, 0);
    chk("pad_count", {16'd0, word_count}, 1);
`endif
    chk("pad_zero", {31'd0, pad_zero}, 1);
    chk("pad_addr", {31'd0, pad_addr}, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
